ysyx_23060061_ifu: RTL

Instruction fetch unit for the single-issue NPC core. It holds the architectural PC and issues one instruction-memory read at a time. It delivers each fetched word, with its PC, to the decoder over a valid/ready handshake. It also accepts control-flow redirects from the execute stage (jal/jalr/branch targets selected by PCSel).

---
 rtl/ysyx_23060061_ifu_pkg.sv | 24 ++
 rtl/ysyx_23060061_ifu_reg.sv | 18 +
 rtl/ysyx_23060061_ifu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ysyx_23060061_ifu_pkg.sv
// Shared IFU definitions: state encodings, reset PC and the fault instruction word.
// Consumed by ysyx_23060061_ifu and its testbench.
package ysyx_23060061_ifu_pkg;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] INST_FAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;

  // Decoder-facing payload, held in one register so it moves atomically
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] word;
  } inst_pkt_t;

  localparam int INST_PKT_W = $bits(inst_pkt_t);

endpackage

// File: rtl/ysyx_23060061_ifu_reg.sv
// Generic enable register with asynchronous active-low reset.
module ysyx_23060061_Reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: one outstanding imem read, valid/ready delivery to decode.
// Optional YSYX_23060061_IFU_PERF_EN adds fetch/stall performance counters.
module ysyx_23060061_ifu
  import ysyx_23060061_ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
`ifdef YSYX_23060061_IFU_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  ifu_state_e state_q, state_d;
  logic       drop_q, drop_d;
  logic       pc_en;
  logic [31:0] pc_q, pc_d;
  logic       cap_en;
  inst_pkt_t  cap_d, out_q;
  logic [INST_PKT_W-1:0] out_bits;
  logic       misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    pc_en          = 1'b0;
    pc_d           = pc_q;
    cap_en         = 1'b0;
    cap_d          = '{fault: imem_resp_err, pc: pc_q, word: imem_resp_data};
    imem_req_valid = 1'b0;
    case (state_q)
      IFU_IDLE: begin
        state_d = IFU_REQ;
        if (redirect_valid) begin
          pc_en  = 1'b1;
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end
      IFU_REQ: begin
        if (misaligned) begin
          // No request goes out, so a redirect here has nothing to drop
          if (redirect_valid) begin
            pc_en = 1'b1;
            pc_d  = redirect_pc;
          end else begin
            cap_en  = 1'b1;
            cap_d   = '{fault: 1'b1, pc: pc_q, word: INST_FAULT};
            state_d = IFU_OUT;
          end
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) state_d = IFU_WAIT;
          if (redirect_valid) begin
            pc_en  = 1'b1;
            pc_d   = redirect_pc;
            drop_d = 1'b1;
          end
        end
      end
      IFU_WAIT: begin
        if (redirect_valid) begin
          pc_en = 1'b1;
          pc_d  = redirect_pc;
          if (imem_resp_valid) begin
            state_d = IFU_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_resp_valid) begin
          state_d = IFU_REQ;
          drop_d  = 1'b0;
          if (!drop_q) begin
            cap_en  = 1'b1;
            state_d = IFU_OUT;
          end
        end
      end
      IFU_OUT: begin
        if (redirect_valid) begin
          pc_en   = 1'b1;
          pc_d    = redirect_pc;
          state_d = IFU_REQ;
        end else if (inst_ready) begin
          pc_en   = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = IFU_REQ;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  ysyx_23060061_Reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .en(pc_en), .d(pc_d), .q(pc_q)
  );

  ysyx_23060061_Reg #(.WIDTH(INST_PKT_W), .RESET_VAL('0)) u_out (
    .clk(clk), .rst_n(rst_n), .en(cap_en), .d(cap_d), .q(out_bits)
  );

  assign out_q         = inst_pkt_t'(out_bits);
  assign imem_req_addr = pc_q;
  assign inst_valid    = (state_q == IFU_OUT);
  assign inst          = out_q.word;
  assign inst_pc       = out_q.pc;
  assign inst_fault    = out_q.fault;

`ifdef YSYX_23060061_IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_valid && inst_ready)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state_q == IFU_WAIT)       perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
